// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: opcodes, ALU/PC codes, FSM states, control bundle and opcode classifiers (HALT_INSN_EN enables HALT)
package cpu_defs_pkg;
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLT   = 6'b011000;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;
`ifdef HALT_INSN_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_LS = 4'b0010,
    S_MEM    = 4'b0011,
    S_WB_LD  = 4'b0100,
    S_EXE_BR = 4'b0101,
    S_EXE_AL = 4'b0110,
    S_WB_AL  = 4'b0111,
    S_HALT   = 4'b1000
  } state_t;
  typedef struct packed {
    logic       pc_wre;
    logic       ir_wre;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       db_data_src;
    logic       reg_wre;
    logic       reg_dst;
    logic       ext_sel;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       m_rd;
    logic       m_wr;
  } ctrl_t;
  function automatic logic is_alu(input logic [5:0] op);
    return op == OP_ADD || op == OP_SUB || op == OP_ADDIU || op == OP_AND ||
           op == OP_ANDI || op == OP_ORI || op == OP_SLT;
  endfunction
  function automatic logic is_br(input logic [5:0] op);
    return op == OP_BEQ || op == OP_BNE;
  endfunction
  function automatic logic is_ls(input logic [5:0] op);
    return op == OP_LW || op == OP_SW;
  endfunction
  function automatic logic is_halt(input logic [5:0] op);
    return HALT_EN && op == OP_HALT;
  endfunction
  function automatic logic is_nop(input logic [5:0] op);
    return !(is_alu(op) || is_br(op) || is_ls(op) || op == OP_J || is_halt(op));
  endfunction
  function automatic logic [2:0] alu_op_of(input logic [5:0] op);
    return (op == OP_SUB || is_br(op)) ? ALU_SUB :
           (op == OP_AND || op == OP_ANDI) ? ALU_AND :
           op == OP_ORI ? ALU_OR :
           op == OP_SLT ? ALU_SLT : ALU_ADD;
  endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational (state, opcode, zero) -> control bundle, all zero when en is low
module ctrl_decode
  import cpu_defs_pkg::*;
(
  input  logic       en,
  input  state_t     st,
  input  logic [5:0] opcode,
  input  logic       zero,
  output ctrl_t      c
);
  logic act, lw, sw, j, nop, take;
  assign act  = st inside {S_ID, S_EXE_AL, S_WB_AL, S_EXE_BR, S_EXE_LS, S_MEM, S_WB_LD};
  assign lw   = opcode == OP_LW;
  assign sw   = opcode == OP_SW;
  assign j    = opcode == OP_J;
  assign nop  = is_nop(opcode);
  assign take = (opcode == OP_BEQ && zero) || (opcode == OP_BNE && !zero);
  always_comb begin
    c = '0;
    c.ir_wre = st == S_IF;
    c.pc_wre = (st == S_ID && (j || nop)) || st == S_EXE_BR || st == S_WB_AL ||
               st == S_WB_LD || (st == S_MEM && sw);
    c.pc_src = (st == S_ID && j) ? PC_JMP : (st == S_EXE_BR && take) ? PC_BR : PC_NEXT;
    c.reg_wre = st == S_WB_AL || st == S_WB_LD;
    c.m_rd = st == S_MEM && lw;
    c.m_wr = st == S_MEM && sw;
    c.db_data_src = st == S_WB_LD;
    c.alu_src_b = act && (opcode == OP_ADDIU || opcode == OP_ANDI || opcode == OP_ORI || lw || sw);
    c.reg_dst = act && (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_SLT);
    c.ext_sel = act && !(opcode == OP_ANDI || opcode == OP_ORI);
    c.alu_op = act ? alu_op_of(opcode) : ALU_ADD;
    if (!en) c = '0;
  end
endmodule

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: multi-cycle CPU control FSM, IF/ID/EXE/MEM/WB sequencing (HALT_INSN_EN enables HALT)
module multi_cycle_control
  import cpu_defs_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  output logic              PCWre,
  output logic              IRWre,
  output logic              ALUSrcA,
  output logic              ALUSrcB,
  output logic              DBDataSrc,
  output logic              RegWre,
  output logic              RegDst,
  output logic              ExtSel,
  output logic [1:0]        PCSrc,
  output logic [ALUOPW-1:0] ALUOp,
  output logic              mRD,
  output logic              mWR,
  output logic [3:0]        state
);
  state_t st, nx;
  ctrl_t c;
  always_ff @(posedge CLK)
    if (!Reset) st <= S_IF;
    else st <= nx;
  always_comb begin
    nx = S_IF;
    case (st)
      S_IF:     nx = S_ID;
      S_ID:     nx = is_alu(opcode) ? S_EXE_AL : is_br(opcode) ? S_EXE_BR :
                     is_ls(opcode) ? S_EXE_LS : is_halt(opcode) ? S_HALT : S_IF;
      S_EXE_AL: nx = S_WB_AL;
      S_EXE_LS: nx = S_MEM;
      S_MEM:    nx = opcode == OP_LW ? S_WB_LD : S_IF;
      S_HALT:   nx = S_HALT;
      default:  nx = S_IF;
    endcase
  end
  ctrl_decode u_dec (
    .en     (Reset),
    .st     (st),
    .opcode (opcode),
    .zero   (zero),
    .c      (c)
  );
  assign PCWre     = c.pc_wre;
  assign IRWre     = c.ir_wre;
  assign ALUSrcA   = c.alu_src_a;
  assign ALUSrcB   = c.alu_src_b;
  assign DBDataSrc = c.db_data_src;
  assign RegWre    = c.reg_wre;
  assign RegDst    = c.reg_dst;
  assign ExtSel    = c.ext_sel;
  assign PCSrc     = c.pc_src;
  assign ALUOp     = c.alu_op;
  assign mRD       = c.m_rd;
  assign mWR       = c.m_wr;
  assign state     = Reset ? st : 4'b0000;
endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control: directed per-cycle checks of state, strobes and selects for each instruction class
module tb_multi_cycle_control;
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0;
  logic [5:0] opcode = 6'b0;
  logic pc_wre, ir_wre, alu_src_a, alu_src_b, db_src, reg_wre, reg_dst, ext_sel, m_rd, m_wr;
  logic [1:0] pc_src;
  logic [2:0] alu_op;
  logic [3:0] state;
  int total = 0, bad = 0;
  localparam logic [11:0] W_IF     = 12'h040;
  localparam logic [11:0] W_ID     = 12'h100;
  localparam logic [11:0] W_ID_J   = 12'h182;
  localparam logic [11:0] W_ID_NOP = 12'h180;
  localparam logic [11:0] W_EXE_AL = 12'h600;
  localparam logic [11:0] W_WB_AL  = 12'h7A0;
  localparam logic [11:0] W_EXE_LS = 12'h200;
  localparam logic [11:0] W_MEM_LW = 12'h310;
  localparam logic [11:0] W_MEM_SW = 12'h388;
  localparam logic [11:0] W_WB_LD  = 12'h4A4;
  localparam logic [11:0] W_BR_T   = 12'h581;
  localparam logic [11:0] W_BR_N   = 12'h580;
  logic [11:0] obs;
  logic [6:0] sel;
  assign obs = {state, pc_wre, ir_wre, reg_wre, m_rd, m_wr, db_src, pc_src};
  assign sel = {alu_src_a, alu_src_b, reg_dst, ext_sel, alu_op};
  multi_cycle_control dut (
    .CLK(clk), .Reset(rst_n), .opcode(opcode), .zero(zero),
    .PCWre(pc_wre), .IRWre(ir_wre), .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b),
    .DBDataSrc(db_src), .RegWre(reg_wre), .RegDst(reg_dst), .ExtSel(ext_sel),
    .PCSrc(pc_src), .ALUOp(alu_op), .mRD(m_rd), .mWR(m_wr), .state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input string tag, input logic [5:0] op, input logic z, input int n,
                     input logic [6:0] sx, input logic [11:0] e0, e1, e2, e3, e4);
    logic [11:0] e [5];
    e = '{e0, e1, e2, e3, e4};
    opcode = op;
    zero = z;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d]", tag, i), obs, e[i]);
      if (i == 2) chk($sformatf("%s_sel", tag), sel, sx);
      step();
    end
    chk($sformatf("%s_back_if", tag), obs, W_IF);
  endtask
  initial begin
    #1;
    chk("rst_t0", {obs, sel}, 19'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_cyc%0d", i), {obs, sel}, 19'h0);
    end
    rst_n = 1'b1;
    #1;
    chk("rel_if", obs, W_IF);
    run("add",   6'b000000, 1'b0, 4, 7'b0011000, W_IF, W_ID, W_EXE_AL, W_WB_AL, 12'h0);
    run("sub",   6'b000001, 1'b0, 4, 7'b0011001, W_IF, W_ID, W_EXE_AL, W_WB_AL, 12'h0);
    run("addiu", 6'b000010, 1'b0, 4, 7'b0101000, W_IF, W_ID, W_EXE_AL, W_WB_AL, 12'h0);
    run("and",   6'b010000, 1'b0, 4, 7'b0011100, W_IF, W_ID, W_EXE_AL, W_WB_AL, 12'h0);
    run("andi",  6'b010001, 1'b0, 4, 7'b0100100, W_IF, W_ID, W_EXE_AL, W_WB_AL, 12'h0);
    run("ori",   6'b010010, 1'b0, 4, 7'b0100011, W_IF, W_ID, W_EXE_AL, W_WB_AL, 12'h0);
    run("slt",   6'b011000, 1'b0, 4, 7'b0011110, W_IF, W_ID, W_EXE_AL, W_WB_AL, 12'h0);
    run("lw",    6'b110001, 1'b0, 5, 7'b0101000, W_IF, W_ID, W_EXE_LS, W_MEM_LW, W_WB_LD);
    run("sw",    6'b110000, 1'b0, 4, 7'b0101000, W_IF, W_ID, W_EXE_LS, W_MEM_SW, 12'h0);
    run("beq_z", 6'b110100, 1'b1, 3, 7'b0001001, W_IF, W_ID, W_BR_T, 12'h0, 12'h0);
    run("beq_n", 6'b110100, 1'b0, 3, 7'b0001001, W_IF, W_ID, W_BR_N, 12'h0, 12'h0);
    run("bne_z", 6'b110101, 1'b1, 3, 7'b0001001, W_IF, W_ID, W_BR_N, 12'h0, 12'h0);
    run("bne_n", 6'b110101, 1'b0, 3, 7'b0001001, W_IF, W_ID, W_BR_T, 12'h0, 12'h0);
    run("j",     6'b111000, 1'b0, 2, 7'b0000000, W_IF, W_ID_J, 12'h0, 12'h0, 12'h0);
    run("ill",   6'b101010, 1'b0, 2, 7'b0000000, W_IF, W_ID_NOP, 12'h0, 12'h0, 12'h0);
    opcode = 6'b110000;
    step();
    step();
    step();
    chk("sw_abort_mem", obs, W_MEM_SW);
    rst_n = 1'b0;
    #1;
    chk("sw_abort_gated", {obs, sel}, 19'h0);
    step();
    chk("sw_abort_edge", {obs, sel}, 19'h0);
    rst_n = 1'b1;
    #1;
    chk("sw_abort_if", obs, W_IF);
    step();
    chk("sw_abort_id", obs, W_ID);
    step();
    chk("sw_abort_exe", obs, W_EXE_LS);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
`ifdef HALT_INSN_EN
    opcode = 6'b111111;
    step();
    chk("halt_id", obs, W_ID);
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("halt_hold%0d", i), {obs, sel}, {12'h800, 7'h0});
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    run("post_halt_j", 6'b111000, 1'b0, 2, 7'b0000000, W_IF, W_ID_J, 12'h0, 12'h0, 12'h0);
`else
    run("halt_nop", 6'b111111, 1'b0, 2, 7'b0000000, W_IF, W_ID_NOP, 12'h0, 12'h0, 12'h0);
`endif
    run("add_end", 6'b000000, 1'b0, 4, 7'b0011000, W_IF, W_ID, W_EXE_AL, W_WB_AL, 12'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Main control FSM of the multi-cycle CPU.
- Sequences each instruction through IF/ID/EXE/MEM/WB.
- Drives every datapath select line, including the `sign` inputs of the 2:1 32-bit selectors (ALU A/B source, writeback data source, register-destination source), plus the write enables and memory strobes.
- Sits upstream of the selectors, ALU, register file and memories; consumes opcode from the IR and flags from the ALU.

Parameters:
- OPW, 6, opcode width.
- ALUOPW, 3, ALU operation code width.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-low reset. Sampled on the rising CLK edge. 0 = reset.
- opcode  input  OPW  instruction opcode from the IR.
- zero  input  1  ALU zero flag.
- PCWre  output  1  PC write enable.
- IRWre  output  1  IR load enable.
- ALUSrcA  output  1  ALU A select: 0 = rs data, 1 = shamt (reserved, driven 0 for all defined opcodes).
- ALUSrcB  output  1  ALU B select: 0 = rt data, 1 = extended immediate.
- DBDataSrc  output  1  writeback select: 0 = ALU result, 1 = memory data.
- RegWre  output  1  register file write enable.
- RegDst  output  1  destination select: 0 = rt, 1 = rd.
- ExtSel  output  1  immediate extension: 0 = zero-extend, 1 = sign-extend.
- PCSrc  output  2  next-PC select: 00 = PC+4, 01 = branch target, 10 = jump target.
- ALUOp  output  ALUOPW  ALU operation.
- mRD  output  1  data memory read strobe.
- mWR  output  1  data memory write strobe.
- state  output  4  current FSM state, for debug and the bench.

Behaviour:
- Opcodes: ADD 000000, SUB 000001, ADDIU 000010, AND 010000, ANDI 010001, ORI 010010, SLT 011000, SW 110000, LW 110001, BEQ 110100, BNE 110101, J 111000, HALT 111111.
- Any other opcode is illegal.
- States and encodings: IF 0000, ID 0001, EXE_AL 0110, WB_AL 0111, EXE_BR 0101, EXE_LS 0010, MEM 0011, WB_LD 0100, HALT 1000.
- Transitions:
  - IF -> ID.
  - ID -> IF for J, illegal, or HALT when HALT is disabled.
  - ID -> EXE_AL for ALU/imm ops; ID -> EXE_BR for BEQ/BNE; ID -> EXE_LS for LW/SW; ID -> HALT for HALT when enabled.
  - EXE_AL -> WB_AL -> IF.
  - EXE_BR -> IF.
  - EXE_LS -> MEM.
  - MEM -> WB_LD for LW; MEM -> IF for SW.
  - WB_LD -> IF.
- Latency in cycles: J 2, illegal 2, BEQ/BNE 3, ALU 4, SW 4, LW 5.
- Outputs are a combinational decode of the registered state and the current opcode. The opcode is stable after IF because IRWre is high only in IF.
- PCWre = 1 for exactly one cycle per instruction:
  - in ID for J and illegal opcodes;
  - in EXE_BR, WB_AL, WB_LD;
  - in MEM for SW.
- PCSrc:
  - 10 in ID for J.
  - 01 in EXE_BR when (BEQ & zero) | (BNE & ~zero).
  - 00 otherwise.
- Strobes:
  - IRWre = 1 only in IF.
  - RegWre = 1 only in WB_AL and WB_LD.
  - mRD = 1 in MEM for LW; mWR = 1 in MEM for SW.
  - DBDataSrc = 1 only in WB_LD.
- Data selects (held constant across EXE, MEM and WB of one instruction):
  - ALUSrcB = 1 for ADDIU/ANDI/ORI/LW/SW.
  - RegDst = 1 for ADD/SUB/AND/SLT.
  - ExtSel = 0 for ANDI/ORI, 1 otherwise.
- ALUOp:
  - 000 ADD/ADDIU/LW/SW.
  - 001 SUB/BEQ/BNE.
  - 100 AND/ANDI.
  - 011 ORI.
  - 110 SLT.
- Outside the states listed above, every strobe and select is 0.
- Reset:
  - When Reset = 0 at a rising edge, state <= IF.
  - While Reset = 0, all outputs are forced to 0 (including IRWre) and state reads 0000.
  - Reset mid-instruction aborts it with no further PCWre, RegWre or mWR.
  - The first IF occurs in the cycle after Reset returns to 1.
- An encoding outside the defined states recovers to IF on the next edge, with all strobes 0.

Optional Feature:
- Macro: HALT_INSN_EN.
- Defined:
  - HALT in ID -> HALT state, with no PCWre.
  - HALT is absorbing, with all strobes 0, until Reset.
- Undefined:
  - HALT behaves as an illegal opcode (NOP, 2 cycles, PC+4).
  - The HALT state is unreachable.

Decomposition:
- Package cpu_defs_pkg holds the opcode constants, ALUOp codes, PCSrc codes and the state encodings.
- One sub-module, ctrl_decode: purely combinational, (state, opcode, zero) -> all control outputs.
- The top keeps only the state register and the next-state logic.

Test Plan:
- Reset held low 3 cycles, then released -> all outputs 0 during reset; state 0000 then 0001; IRWre = 1 in the first cycle after release.
- ADD (000000) -> states IF, ID, EXE_AL, WB_AL; RegDst = 1, ALUOp = 000; RegWre = 1 and PCWre = 1 only in WB_AL.
- LW (110001) -> 5 cycles; mRD = 1 in MEM; DBDataSrc = 1 and RegWre = 1 in WB_LD; ALUSrcB = 1, ExtSel = 1.
- BEQ with zero = 1 -> PCSrc = 01 and PCWre = 1 in EXE_BR. BNE with zero = 1 -> PCSrc = 00.
- J (111000) -> PCSrc = 10 and PCWre = 1 in ID; back in IF next cycle. Opcode 101010 -> NOP, PCSrc = 00.
- Reset driven low in MEM of SW -> mWR never asserted after that edge; state = IF. With HALT_INSN_EN, HALT -> state 1000 held for 20 cycles, PCWre = 0.
